btb_update_scheduler: RTL and testbench

Write-port controller for the branch target buffer. Collects target-update requests from two pipeline resolve points (EX and MEM), arbitrates and queues them in a small FIFO, and drains one write per cycle into the BTB's single write port whenever that port is not stalled. It also clears every BTB entry to zero after reset and on a flush request, because the target storage has no reset of its own.

---
 rtl/btb_update_scheduler.sv | 161 ++++++++++++++++
 tb/tb_btb_update_scheduler.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/btb_update_scheduler.sv
// btb_update_scheduler
// Write-port controller for the branch target buffer.
// Collects target updates from EX and MEM, arbitrates between them and queues
// {index, target} pairs in a small FIFO. The FIFO drains one BTB write per
// non-stalled cycle. After reset, and on flush_req, the controller sweeps every
// BTB entry to zero, because the target storage has no reset of its own.
//
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   ex_valid/ex_pc/ex_target  update request from EX
//   mem_valid/mem_pc/...      update request from MEM; wins over EX
//   flush_req                 single-cycle request to re-clear the whole BTB
//   stall                     BTB write port unavailable this cycle
//   btb_we/windex/wdata       BTB write port (combinational)
//   busy                      clear sweep in progress
//   full                      update FIFO full
//   drop_cnt                  saturating count of discarded requests
module btb_update_scheduler #(
    parameter int S_INDEX    = 7,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_valid,
    input  logic [31:0]        ex_pc,
    input  logic [31:0]        ex_target,
    input  logic               mem_valid,
    input  logic [31:0]        mem_pc,
    input  logic [31:0]        mem_target,
    input  logic               flush_req,
    input  logic               stall,
    output logic               btb_we,
    output logic [S_INDEX-1:0] btb_windex,
    output logic [31:0]        btb_wdata,
    output logic               busy,
    output logic               full,
    output logic [7:0]         drop_cnt
);
    localparam int                 AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]        DEPTH_C  = (AW+1)'(FIFO_DEPTH);
    localparam logic [S_INDEX-1:0] LAST_IDX = '1;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t             state, state_nxt;
    logic [S_INDEX-1:0] clr_idx;

    logic [S_INDEX-1:0] fifo_idx [FIFO_DEPTH];
    logic [31:0]        fifo_tgt [FIFO_DEPTH];
    logic [AW-1:0]      rd_ptr, wr_ptr, tail_ptr;
    logic [AW:0]        count;
    logic               empty;

    logic               pop, push, coalesce, run_ok;
    logic               req_v;
    logic [S_INDEX-1:0] req_idx;
    logic [31:0]        req_tgt;
    logic [1:0]         drop_inc;
    logic [8:0]         drop_sum;

    assign empty    = (count == '0);
    assign full     = (count == DEPTH_C);
    assign busy     = (state == CLEAR);
    assign tail_ptr = wr_ptr - 1'b1;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= CLEAR;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        btb_we     = 1'b0;
        btb_windex = clr_idx;
        btb_wdata  = '0;
        pop        = 1'b0;
        case (state)
            CLEAR: begin
                btb_we = !stall;
                if (!stall && clr_idx == LAST_IDX) state_nxt = RUN;
            end
            RUN: begin
                btb_windex = fifo_idx[rd_ptr];
                btb_wdata  = fifo_tgt[rd_ptr];
                btb_we     = !empty && !stall;
                pop        = !empty && !stall;
            end
            default: state_nxt = CLEAR;
        endcase
        // Flush wins: the head stays queued (it is discarded anyway) and the
        // sweep restarts from index 0.
        if (flush_req) begin
            state_nxt = CLEAR;
            pop       = 1'b0;
        end
        if (rst) btb_we = 1'b0;
    end

    // ---------------- request arbitration ----------------
    assign req_v   = ex_valid || mem_valid;
    assign req_idx = mem_valid ? mem_pc[2 +: S_INDEX] : ex_pc[2 +: S_INDEX];
    assign req_tgt = mem_valid ? mem_target : ex_target;
    assign run_ok  = (state == RUN) && !flush_req;

    // Overwrite the tail in place unless the tail is also the head leaving
    // this cycle; then the entry would vanish, so push a fresh one instead.
    assign coalesce = run_ok && req_v && !empty &&
                      (fifo_idx[tail_ptr] == req_idx) && !(pop && count == 1);
    assign push     = run_ok && req_v && !coalesce && (!full || pop);

    always_comb begin
        drop_inc = 2'd0;
        if (!run_ok)
            drop_inc = {1'b0, ex_valid} + {1'b0, mem_valid};
        else
            drop_inc = {1'b0, ex_valid && mem_valid} +
                       {1'b0, req_v && !coalesce && !push};
    end

    assign drop_sum = {1'b0, drop_cnt} + {7'b0, drop_inc};

    // ---------------- sweep counter, FIFO pointers, drop counter ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_idx  <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else begin
            drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
            if (flush_req) begin
                clr_idx <= '0;
                rd_ptr  <= '0;
                wr_ptr  <= '0;
                count   <= '0;
            end else begin
                // clr_idx wraps back to 0 after the last index, ready for the next sweep
                if (state == CLEAR && !stall) clr_idx <= clr_idx + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                if (push) wr_ptr <= wr_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Queue storage needs no reset: entries are only read when count says valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_idx[wr_ptr] <= req_idx;
            fifo_tgt[wr_ptr] <= req_tgt;
        end else if (coalesce) begin
            fifo_tgt[tail_ptr] <= req_tgt;
        end
    end
endmodule

// File: tb/tb_btb_update_scheduler.sv
module tb_btb_update_scheduler;
    localparam int S_INDEX    = 3;
    localparam int FIFO_DEPTH = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               ex_valid, mem_valid, flush_req, stall;
    logic [31:0]        ex_pc, ex_target, mem_pc, mem_target;
    logic               btb_we, busy, full;
    logic [S_INDEX-1:0] btb_windex;
    logic [31:0]        btb_wdata;
    logic [7:0]         drop_cnt;

    int errors = 0;
    int checks = 0;

    btb_update_scheduler #(.S_INDEX(S_INDEX), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_target(ex_target),
        .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_target(mem_target),
        .flush_req(flush_req), .stall(stall),
        .btb_we(btb_we), .btb_windex(btb_windex), .btb_wdata(btb_wdata),
        .busy(busy), .full(full), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // advance one edge; inputs are then changed well away from the next edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid = 0; mem_valid = 0; flush_req = 0;
        ex_pc = 0; ex_target = 0; mem_pc = 0; mem_target = 0;
    endtask

    task automatic chk_wr(input string tag, input logic we, input int idx, input logic [31:0] data);
        chk({tag, "_we"}, 32'(btb_we), 32'(we));
        if (we) begin
            chk({tag, "_idx"}, 32'(btb_windex), 32'(idx));
            chk({tag, "_data"}, btb_wdata, data);
        end
    endtask

    initial begin
        idle();
        stall = 0;
        rst   = 1;
        #12;
        // --- reset state
        chk("rst_we", 32'(btb_we), 0);
        chk("rst_idx", 32'(btb_windex), 0);
        chk("rst_data", btb_wdata, 0);
        chk("rst_busy", 32'(busy), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_drop", 32'(drop_cnt), 0);

        // --- power-on sweep: 8 writes of zero, then idle
        tick();
        rst = 0;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk_wr("sweep", 1, i, 0);
            chk("sweep_busy", 32'(busy), 1);
            tick();
        end
        chk("sweep_done_busy", 32'(busy), 0);
        chk("sweep_done_we", 32'(btb_we), 0);
        chk("sweep_drop", 32'(drop_cnt), 0);

        // --- single EX update, written the cycle after acceptance
        ex_valid = 1; ex_pc = 32'h10; ex_target = 32'h400;
        tick();
        idle();
        #1;
        chk_wr("ex1", 1, 4, 32'h400);
        tick();
        chk("ex1_after_we", 32'(btb_we), 0);

        // --- both sources: MEM wins, EX dropped
        ex_valid = 1; ex_pc = 32'h8; ex_target = 32'h111;
        mem_valid = 1; mem_pc = 32'hC; mem_target = 32'h222;
        tick();
        idle();
        #1;
        chk_wr("arb", 1, 3, 32'h222);
        chk("arb_drop", 32'(drop_cnt), 1);
        tick();
        chk("arb_after_we", 32'(btb_we), 0);

        // --- stalled: 6 distinct pushes into 4 entries
        stall = 1;
        for (int i = 0; i < 6; i++) begin
            ex_valid = 1; ex_pc = 32'(i * 4); ex_target = 32'hA0 + 32'(i);
            tick();
            if (i == 2) chk("fill3_full", 32'(full), 0);
            if (i == 3) chk("fill4_full", 32'(full), 1);
        end
        idle();
        #1;
        chk("ovf_we", 32'(btb_we), 0);
        chk("ovf_full", 32'(full), 1);
        chk("ovf_drop", 32'(drop_cnt), 3);
        stall = 0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk_wr("drain", 1, i, 32'hA0 + 32'(i));
            tick();
        end
        chk("drain_done_we", 32'(btb_we), 0);
        chk("drain_done_full", 32'(full), 0);

        // --- coalescing two updates to the same index while stalled
        stall = 1;
        ex_valid = 1; ex_pc = 32'h20; ex_target = 32'h100;
        tick();
        ex_target = 32'h200;
        tick();
        idle();
        stall = 0;
        #1;
        chk_wr("coal", 1, 0, 32'h200);
        tick();
        chk("coal_after_we", 32'(btb_we), 0);
        chk("coal_drop", 32'(drop_cnt), 3);

        // --- flush, then restart the sweep from clr_idx=5
        flush_req = 1;
        tick();
        idle();
        #1;
        chk("flush_busy", 32'(busy), 1);
        for (int i = 0; i < 5; i++) begin
            chk_wr("fl_sweep", 1, i, 0);
            tick();
        end
        flush_req = 1; ex_valid = 1; ex_pc = 32'h4;
        #1;
        chk_wr("fl_at5", 1, 5, 0);
        tick();
        idle();
        ex_valid = 1; mem_valid = 1; ex_pc = 32'h4; mem_pc = 32'h8;
        #1;
        chk_wr("restart0", 1, 0, 0);
        chk("restart_drop", 32'(drop_cnt), 4);
        tick();
        idle();
        #1;
        chk("clr_both_drop", 32'(drop_cnt), 6);
        for (int i = 1; i < 8; i++) begin
            chk_wr("restart", 1, i, 0);
            tick();
        end
        chk("restart_done_busy", 32'(busy), 0);
        chk("restart_done_we", 32'(btb_we), 0);

        // --- stall during the sweep holds clr_idx
        flush_req = 1;
        tick();
        idle();
        tick();
        stall = 1;
        #1;
        chk("sweep_stall_we", 32'(btb_we), 0);
        tick();
        tick();
        stall = 0;
        #1;
        chk_wr("sweep_hold", 1, 1, 0);

        // --- mid-operation reset
        rst = 1;
        #1;
        chk("mrst_we", 32'(btb_we), 0);
        chk("mrst_drop", 32'(drop_cnt), 0);
        chk("mrst_busy", 32'(busy), 1);
        tick();
        rst = 0;
        #1;
        chk_wr("mrst_first", 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
